splitmix_gen: RTL and testbench

Parametrised, handshaked SplitMix64 pseudo-random word generator. It is the successor to the free-running 32-bit splitmix source and adds the following:
- seed loading
- valid/ready backpressure without loss
- configurable output width
- a split mode that delivers both 32-bit halves of each 64-bit result

The mixer is a 3-stage pipeline that sustains 1 word/cycle. The block feeds the crypto datapath's nonce/mask consumers.

---
 rtl/splitmix_gen.sv | 98 +++++++++
 tb/tb_splitmix_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/splitmix_gen.sv
// Handshaked SplitMix64 word generator: 64-bit state stepped by GAMMA and fed
// into a 3-stage mixer pipeline that advances only when its output slot frees.
module splitmix_gen #(
    parameter int          OUT_W = 32,
    parameter bit          SPLIT = 1'b0,
    parameter logic [63:0] SEED  = 64'h0,
    parameter logic [63:0] GAMMA = 64'h9E3779B97F4A7C15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [63:0]      seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out
);

    localparam logic [63:0] MUL1 = 64'hBF58476D1CE4E5B9;
    localparam logic [63:0] MUL2 = 64'h94D049BB133111EB;

    if (!((OUT_W == 32) || (OUT_W == 64)) || (SPLIT && (OUT_W != 32))) begin : g_bad_params
        $error("splitmix_gen: OUT_W must be 32 or 64, SPLIT=1 requires OUT_W=32");
    end

    logic [63:0] z_q, z_d;
    logic [63:0] s1_q, s1_d;
    logic [63:0] s2_q, s2_d;
    logic [63:0] s3_q, s3_d;
    logic        v1_q, v1_d;
    logic        v2_q, v2_d;
    logic        v3_q, v3_d;
    logic        half_q, half_d;
    logic [63:0] t;
    logic        adv;
    logic        xfer;

    always_comb begin
        t      = z_q + GAMMA;
        // In split mode the pipeline only moves once the lower half is taken.
        adv    = !v3_q || (out_ready && (!SPLIT || half_q));
        xfer   = v3_q && out_ready;
        z_d    = z_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        s3_d   = s3_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        v3_d   = v3_q;
        half_d = half_q;
        if (seed_load) begin
            z_d    = seed;
            v1_d   = 1'b0;
            v2_d   = 1'b0;
            v3_d   = 1'b0;
            half_d = 1'b0;
        end else begin
            if (SPLIT && xfer) begin
                half_d = !half_q;
            end
            if (adv) begin
                z_d  = t;
                s1_d = (t ^ (t >> 30)) * MUL1;
                s2_d = (s1_q ^ (s1_q >> 27)) * MUL2;
                s3_d = s2_q ^ (s2_q >> 31);
                v1_d = 1'b1;
                v2_d = v1_q;
                v3_d = v2_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q    <= SEED;
            s1_q   <= 64'h0;
            s2_q   <= 64'h0;
            s3_q   <= 64'h0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            half_q <= 1'b0;
        end else begin
            z_q    <= z_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            half_q <= half_d;
        end
    end

    // Narrow output takes the upper half unless the lower half is being presented.
    assign out_valid = v3_q;
    assign out       = OUT_W'((SPLIT && half_q) ? s3_q : (s3_q >> (64 - OUT_W)));

endmodule

// File: tb/tb_splitmix_gen.sv
// Bench for splitmix_gen: three instances (64-bit, 32-bit upper, 32-bit split)
// compared against a plain SplitMix64 reference function.
module tb_splitmix_gen;

    localparam logic [63:0] GAMMA = 64'h9E3779B97F4A7C15;
    localparam logic [63:0] C1    = 64'hBF58476D1CE4E5B9;
    localparam logic [63:0] C2    = 64'h94D049BB133111EB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [63:0] seed = 64'h0;
    logic [2:0]  rdy = 3'b000;
    logic        v64, v32, v32s;
    logic [63:0] o64;
    logic [31:0] o32, o32s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    splitmix_gen #(.OUT_W(64), .SPLIT(1'b0)) u_d64 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .out_ready(rdy[0]), .out_valid(v64), .out(o64));
    splitmix_gen #(.OUT_W(32), .SPLIT(1'b0)) u_d32 (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .out_ready(rdy[1]), .out_valid(v32), .out(o32));
    splitmix_gen #(.OUT_W(32), .SPLIT(1'b1)) u_d32s (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
        .out_ready(rdy[2]), .out_valid(v32s), .out(o32s));

    // k-th 64-bit result of a generator seeded with s
    function automatic logic [63:0] ref_mix(input logic [63:0] s, input int unsigned k);
        logic [63:0] z;
        z = s + GAMMA * (64'(k) + 64'd1);
        z = (z ^ (z >> 30)) * C1;
        z = (z ^ (z >> 27)) * C2;
        return z ^ (z >> 31);
    endfunction

    // k-th word delivered by instance `which`
    function automatic logic [63:0] ref_word(input int which, input logic [63:0] s, input int unsigned k);
        logic [63:0] w;
        case (which)
            0: return ref_mix(s, k);
            1: begin w = ref_mix(s, k); return {32'h0, w[63:32]}; end
            default: begin
                w = ref_mix(s, k / 2);
                return (k % 2 == 1) ? {32'h0, w[31:0]} : {32'h0, w[63:32]};
            end
        endcase
    endfunction

    function automatic void sample(input int which, output logic v, output logic [63:0] o);
        case (which)
            0: begin v = v64; o = o64; end
            1: begin v = v32; o = {32'h0, o32}; end
            default: begin v = v32s; o = {32'h0, o32s}; end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        seed_load = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Accept nwords from one instance, checking each against the model and
    // checking that a stalled word stays put.
    task automatic check_stream(input int which, input logic [63:0] s, input int nwords, input bit rnd);
        int unsigned k = 0;
        int budget = 0;
        logic v, pv, pr, r;
        logic [63:0] o, po, exp_w;
        pv = 1'b0; pr = 1'b0; po = 64'h0;
        while (k < nwords && budget < 2000) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy[which] = r;
            sample(which, v, o);
            if (pv && !pr) begin
                n_checks++;
                if (v !== 1'b1 || o !== po) begin
                    n_fail++;
                    $display("FAIL hold_stable inst=%0d got valid=%b out=%h required valid=1 out=%h", which, v, o, po);
                end
            end
            if (v && r) begin
                exp_w = ref_word(which, s, k);
                n_checks++;
                if (o !== exp_w) begin
                    n_fail++;
                    $display("FAIL stream_word inst=%0d idx=%0d got %h required %h", which, k, o, exp_w);
                end
                k++;
            end
            pv = v; pr = r; po = o;
            tick;
            budget++;
        end
        if (k < nwords) begin
            n_checks++;
            n_fail++;
            $display("FAIL stream_timeout inst=%0d got %0d words required %0d", which, k, nwords);
        end
    endtask

    task automatic test_reset;
        logic v;
        logic [63:0] o;
        logic [63:0] kv [3];
        logic [31:0] ks [6];
        kv = '{64'hE220A8397B1DCDAF, 64'h6E789E6AA1B965F4, 64'h06C45D188009454F};
        ks = '{32'hE220A839, 32'h7B1DCDAF, 32'h6E789E6A, 32'hA1B965F4, 32'h06C45D18, 32'h8009454F};
        rdy = 3'b111;
        seed = 64'h0;
        do_reset;
        for (int w = 0; w < 3; w++) begin
            sample(w, v, o);
            n_checks++;
            if (v !== 1'b0 || o !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_state inst=%0d got valid=%b out=%h required valid=0 out=0", w, v, o);
            end
        end
        for (int e = 1; e <= 3; e++) begin
            tick;
            for (int w = 0; w < 3; w++) begin
                sample(w, v, o);
                n_checks++;
                if (v !== (e == 3)) begin
                    n_fail++;
                    $display("FAIL latency inst=%0d edge=%0d got valid=%b required %b", w, e, v, (e == 3));
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                n_checks++;
                if (v64 !== 1'b1 || o64 !== kv[i]) begin
                    n_fail++;
                    $display("FAIL known64 idx=%0d got valid=%b out=%h required %h", i, v64, o64, kv[i]);
                end
                o = kv[i];
                n_checks++;
                if (v32 !== 1'b1 || o32 !== o[63:32]) begin
                    n_fail++;
                    $display("FAIL known32 idx=%0d got valid=%b out=%h required %h", i, v32, o32, o[63:32]);
                end
            end
            n_checks++;
            if (v32s !== 1'b1 || o32s !== ks[i]) begin
                n_fail++;
                $display("FAIL known_split idx=%0d got valid=%b out=%h required %h", i, v32s, o32s, ks[i]);
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        rdy = 3'b000;
        do_reset;
        tick; tick; tick;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (v64 !== 1'b1 || o64 !== 64'hE220A8397B1DCDAF) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d got valid=%b out=%h required valid=1 out=E220A8397B1DCDAF", c, v64, o64);
            end
            tick;
        end
        check_stream(0, 64'h0, 3, 1'b0);
        for (int w = 0; w < 3; w++) begin
            rdy = 3'b000;
            do_reset;
            check_stream(w, 64'h0, 40, 1'b1);
        end
    endtask

    task automatic test_seed_load;
        logic [63:0] s;
        rdy = 3'b001;
        do_reset;
        check_stream(0, 64'h0, 10, 1'b0);
        seed_load = 1'b1;
        seed = 64'h0;
        tick;
        seed_load = 1'b0;
        for (int e = 0; e <= 3; e++) begin
            n_checks++;
            if (v64 !== (e == 3)) begin
                n_fail++;
                $display("FAIL seed_valid edge=%0d got %b required %b", e, v64, (e == 3));
            end
            if (e < 3) tick;
        end
        n_checks++;
        if (o64 !== 64'hE220A8397B1DCDAF) begin
            n_fail++;
            $display("FAIL seed_restart got %h required E220A8397B1DCDAF", o64);
        end
        check_stream(0, 64'h0, 3, 1'b0);
        s = {$urandom, $urandom};
        seed_load = 1'b1;
        seed = s;
        tick;
        seed_load = 1'b0;
        check_stream(0, s, 8, 1'b1);
        // reset wins over a simultaneous seed load
        rdy = 3'b001;
        rst = 1'b1;
        seed_load = 1'b1;
        seed = s | 64'h1;
        tick;
        rst = 1'b0;
        seed_load = 1'b0;
        n_checks++;
        if (v64 !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_seed_valid got %b required 0", v64);
        end
        check_stream(0, 64'h0, 3, 1'b0);
    endtask

    task automatic test_rst_midstream;
        logic [63:0] exp_w;
        rdy = 3'b100;
        do_reset;
        check_stream(2, 64'h0, 5, 1'b0);
        exp_w = ref_word(2, 64'h0, 5);
        n_checks++;
        if (v32s !== 1'b1 || {32'h0, o32s} !== exp_w) begin
            n_fail++;
            $display("FAIL lower_half got valid=%b out=%h required valid=1 out=%h", v32s, o32s, exp_w);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_checks++;
        if (v32s !== 1'b0 || o32s !== 32'h0) begin
            n_fail++;
            $display("FAIL midstream_reset got valid=%b out=%h required valid=0 out=0", v32s, o32s);
        end
        check_stream(2, 64'h0, 4, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_backpressure;
        test_seed_load;
        test_rst_midstream;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
